// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, default constants and address helpers for the
// data-memory arbiter.
//   owner_e       - which port owns the response slot in the next cycle
//   DEF_BASE_ADDR - default byte address of memory word 0
//   DEF_NEL       - default number of memory words
//   addr_ok()     - alignment and range check of a byte address
//   word_idx()    - byte address to word index (untruncated)
// The helpers work on 64-bit values so that BASE_ADDR + 4*NEL cannot wrap.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam int DEF_BASE_ADDR = 8192;
  localparam int DEF_NEL       = 1024;

  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] nel);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr < (base + (nel << 2)));
  endfunction

  function automatic logic [63:0] word_idx(input logic [63:0] addr,
                                           input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/dmem_arb_port_chk.sv
// dmem_arb_port_chk: combinational per-port address checker.
// Ports:
//   addr - requester byte address (ADDR_N bits)
//   ok   - 1 when the address is word aligned and inside the memory window
//   idx  - word index into the memory, clog2(NEL) bits
module dmem_arb_port_chk
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_N    = 32,
  parameter int NEL       = DEF_NEL,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  localparam int AW       = $clog2(NEL)
) (
  input  logic [ADDR_N-1:0] addr,
  output logic              ok,
  output logic [AW-1:0]     idx
);

  logic [63:0] addr_ext;
  logic [63:0] idx_full;
  logic        unused_idx_hi;

  assign addr_ext = 64'(addr);
  assign ok       = addr_ok(addr_ext, 64'(BASE_ADDR), 64'(NEL));
  assign idx_full = word_idx(addr_ext, 64'(BASE_ADDR));

  // Upper index bits are beyond the memory and are dropped on purpose.
  assign idx           = idx_full[AW-1:0];
  assign unused_idx_hi = ^idx_full[63:AW];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core data
// port (port 0) and an auxiliary loader/debug master (port 1).
// Ports:
//   CLK, RSTN                 - clock, asynchronous active-low reset
//   REQn/WEn/ADDRn/WDATAn     - request, write enable, byte address, write data
//   GNTn                      - request accepted this cycle (combinational)
//   RVALIDn/ERRn/RDATAn       - response one cycle after GNTn
//   MEM_ADDR/MEM_WR_EN/MEM_RD_EN/MEM_DATA_IN/MEM_DATA_OUT - memory side
// Optional build macro DMEM_ARB_STATS_EN adds STAT_CLR input and the
// saturating STAT_GNT0/STAT_GNT1/STAT_ERR counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_N     = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NEL        = DEF_NEL,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int MAX_BURST  = 4,
  localparam int AW        = $clog2(NEL)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_N-1:0]     ADDR0,
  input  logic [ADDR_N-1:0]     ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic                  ERR0,
  output logic                  ERR1,
  output logic [DATA_WIDTH-1:0] RDATA0,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [AW-1:0]         MEM_ADDR,
  output logic                  MEM_WR_EN,
  output logic                  MEM_RD_EN,
  output logic [DATA_WIDTH-1:0] MEM_DATA_IN,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_OUT
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic                  STAT_CLR,
  output logic [31:0]           STAT_GNT0,
  output logic [31:0]           STAT_GNT1,
  output logic [15:0]           STAT_ERR
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  logic          ok0, ok1;
  logic [AW-1:0] idx0, idx1;
  logic          gnt0, gnt1;
  logic          sel_err, sel_rd;

  logic [CW-1:0] burst_q, burst_d;
  owner_e        owner_q, owner_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;

  dmem_arb_port_chk #(
    .ADDR_N   (ADDR_N),
    .NEL      (NEL),
    .BASE_ADDR(BASE_ADDR)
  ) u_chk0 (
    .addr(ADDR0),
    .ok  (ok0),
    .idx (idx0)
  );

  dmem_arb_port_chk #(
    .ADDR_N   (ADDR_N),
    .NEL      (NEL),
    .BASE_ADDR(BASE_ADDR)
  ) u_chk1 (
    .addr(ADDR1),
    .ok  (ok1),
    .idx (idx1)
  );

  // Core-priority arbitration. The burst counter tracks consecutive
  // contested grants to port 0; once it reaches the limit port 1 gets one
  // grant. Nothing is granted while reset is held.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    burst_d = '0;
    if (RSTN) begin
      if (REQ0 && REQ1) begin
        if (burst_q < BURST_LIMIT) begin
          gnt0    = 1'b1;
          burst_d = burst_q + CW'(1);
        end else begin
          gnt1    = 1'b1;
        end
      end else begin
        gnt0 = REQ0;
        gnt1 = REQ1;
      end
    end
  end

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;

  // Memory command in the grant cycle. Error accesses are granted but drive
  // no strobe, so the memory never sees an out-of-window address.
  always_comb begin
    MEM_ADDR    = '0;
    MEM_WR_EN   = 1'b0;
    MEM_RD_EN   = 1'b0;
    MEM_DATA_IN = '0;
    sel_err     = 1'b0;
    sel_rd      = 1'b0;
    if (gnt0) begin
      sel_err = !ok0;
      sel_rd  = !WE0;
      if (ok0) begin
        MEM_ADDR    = idx0;
        MEM_WR_EN   = WE0;
        MEM_RD_EN   = !WE0;
        MEM_DATA_IN = WDATA0;
      end
    end else if (gnt1) begin
      sel_err = !ok1;
      sel_rd  = !WE1;
      if (ok1) begin
        MEM_ADDR    = idx1;
        MEM_WR_EN   = WE1;
        MEM_RD_EN   = !WE1;
        MEM_DATA_IN = WDATA1;
      end
    end
  end

  // Response-owner FSM: the port granted this cycle owns next cycle's
  // response slot; without a grant the slot is empty.
  always_comb begin
    owner_d = OWN_NONE;
    err_d   = sel_err;
    rd_d    = sel_rd;
    if (gnt0) begin
      owner_d = OWN_P0;
    end else if (gnt1) begin
      owner_d = OWN_P1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      burst_q <= burst_d;
    end
  end

  // Read data comes straight from the memory output in the response cycle;
  // it is forced to zero for errors and writes.
  always_comb begin
    RVALID0 = (owner_q == OWN_P0);
    RVALID1 = (owner_q == OWN_P1);
    ERR0    = RVALID0 && err_q;
    ERR1    = RVALID1 && err_q;
    RDATA0  = (RVALID0 && rd_q && !err_q) ? MEM_DATA_OUT : '0;
    RDATA1  = (RVALID1 && rd_q && !err_q) ? MEM_DATA_OUT : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt0_d;
  logic [31:0] stat_gnt1_q, stat_gnt1_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic        err_resp;

  assign err_resp = (owner_q != OWN_NONE) && err_q;

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_comb begin
    stat_gnt0_d = stat_gnt0_q;
    stat_gnt1_d = stat_gnt1_q;
    stat_err_d  = stat_err_q;
    if (STAT_CLR) begin
      stat_gnt0_d = '0;
      stat_gnt1_d = '0;
      stat_err_d  = '0;
    end else begin
      if (gnt0 && (stat_gnt0_q != '1)) stat_gnt0_d = stat_gnt0_q + 32'd1;
      if (gnt1 && (stat_gnt1_q != '1)) stat_gnt1_d = stat_gnt1_q + 32'd1;
      if (err_resp && (stat_err_q != '1)) stat_err_d = stat_err_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stat_gnt0_q <= '0;
      stat_gnt1_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_gnt0_q <= stat_gnt0_d;
      stat_gnt1_q <= stat_gnt1_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign STAT_GNT0 = stat_gnt0_q;
  assign STAT_GNT1 = stat_gnt1_q;
  assign STAT_ERR  = stat_err_q;
`endif

endmodule
